led_matrix_scan: RTL and testbench

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

---
 rtl/led_scan_pkg.sv | 29 ++
 rtl/led_scan_timer.sv | 49 ++++
 rtl/led_matrix_scan.sv | 136 +++++++++++++
 tb/tb_led_matrix_scan.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix scanner.
package led_scan_pkg;

    // Scan controller states: parked, dead-time at slot start, driving LEDs
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Brightness PWM repeats every 16 drive clocks, so 4-bit phase/level
    localparam int PWM_PERIOD = 16;
    localparam int PWM_W      = $clog2(PWM_PERIOD);

    localparam int DEF_NUM_ROWS       = 5;
    localparam int DEF_NUM_COLS       = 8;
    localparam int DEF_SCAN_DIV       = 256;
    localparam int DEF_BLANK_CYCLES   = 16;
    localparam int DEF_ROW_ACTIVE_LOW = 0;
    localparam int DEF_COL_ACTIVE_LOW = 1;

    // A column is lit for PWM phases 0..level, so level 15 is always on
    // and level 0 gives one clock in every PWM period.
    function automatic logic pwm_lit(input logic [PWM_W-1:0] phase,
                                     input logic [PWM_W-1:0] level);
        return (phase <= level);
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot and row counters for the LED matrix scanner, plus the slot-wrap
// and frame-start strobes derived from them.
module led_scan_timer
    import led_scan_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        stop,
    output logic [$clog2(SCAN_DIV)-1:0] slot_cnt,
    output logic [$clog2(NUM_ROWS)-1:0] row_idx,
    output logic                        slot_wrap,
    output logic                        frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);

    assign slot_wrap   = run && (slot_cnt == SLOT_LAST);
    assign frame_start = run && (slot_cnt == '0) && (row_idx == '0);

    // Counters sit at zero while parked; on the last clock of a slot the
    // row advances, or returns to row 0 when the scan is stopping so the
    // controller parks already aligned to a fresh frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (!run) begin
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            if (stop || (row_idx == ROW_LAST)) begin
                row_idx <= '0;
            end else begin
                row_idx <= row_idx + ROW_W'(1);
            end
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix scanner: one row per time slot, blanking dead
// time at the start of each slot, 16-step brightness PWM on the columns,
// and a frame snapshot so mid-frame data changes never tear a frame.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int NUM_ROWS       = DEF_NUM_ROWS,
    parameter int NUM_COLS       = DEF_NUM_COLS,
    parameter int SCAN_DIV       = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter int ROW_ACTIVE_LOW = DEF_ROW_ACTIVE_LOW,
    parameter int COL_ACTIVE_LOW = DEF_COL_ACTIVE_LOW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [3:0]                   bright,
    input  logic [NUM_ROWS*NUM_COLS-1:0] frame_data,
    output logic [NUM_ROWS-1:0]          led_row,
    output logic [NUM_COLS-1:0]          led_col,
    output logic [$clog2(NUM_ROWS)-1:0]  row_idx,
    output logic                         frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]    BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [NUM_ROWS-1:0] ROW_INV   = (ROW_ACTIVE_LOW != 0) ? {NUM_ROWS{1'b1}} : '0;
    localparam logic [NUM_COLS-1:0] COL_INV   = (COL_ACTIVE_LOW != 0) ? {NUM_COLS{1'b1}} : '0;

    // The slot must hold the blanking time plus at least one full PWM period
    if (SCAN_DIV < BLANK_CYCLES + PWM_PERIOD) begin : g_bad_scan_div
        $error("led_matrix_scan: SCAN_DIV must be >= BLANK_CYCLES + 16");
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
        $error("led_matrix_scan: BLANK_CYCLES must not be negative");
    end

    scan_state_t                 state_q;
    scan_state_t                 state_d;
    logic [CNT_W-1:0]            slot_cnt;
    logic [CNT_W-1:0]            slot_nxt;
    logic                        slot_wrap;
    logic                        running;
    logic [NUM_ROWS*NUM_COLS-1:0] snapshot;
    logic [NUM_COLS-1:0]         snap_row;
    logic [PWM_W-1:0]            pwm_phase;
    logic [NUM_ROWS-1:0]         row_drv;
    logic [NUM_COLS-1:0]         col_drv;

    assign running = (state_q != ST_IDLE);

    led_scan_timer #(
        .NUM_ROWS (NUM_ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .run         (running),
        .stop        (!enable),
        .slot_cnt    (slot_cnt),
        .row_idx     (row_idx),
        .slot_wrap   (slot_wrap),
        .frame_start (frame_start)
    );

    // State register for the scan controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on enable; while scanning, pick BLANK/DRIVE from
    // the upcoming slot count, and only park at a slot boundary so the row
    // that is on screen always gets its full slot. Enable is judged at that
    // boundary, so re-raising it before the slot ends cancels the stop.
    always_comb begin
        state_d  = state_q;
        slot_nxt = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
                end
            end
            ST_BLANK, ST_DRIVE: begin
                if (slot_wrap && !enable) begin
                    state_d = ST_IDLE;
                end else if (slot_nxt < BLANK_LIM) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame snapshot, captured on the first clock of each frame only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
        end else if (frame_start) begin
            snapshot <= frame_data;
        end
    end

    // Row/column drive: everything inactive unless in DRIVE; the live
    // frame_data is used on the capture clock so a zero-length blanking
    // window still shows the new frame in its very first drive clock.
    always_comb begin
        snap_row  = frame_start ? frame_data[row_idx*NUM_COLS +: NUM_COLS]
                                : snapshot[row_idx*NUM_COLS +: NUM_COLS];
        pwm_phase = PWM_W'(slot_cnt - BLANK_LIM);
        row_drv   = ROW_INV;
        col_drv   = COL_INV;
        if (state_q == ST_DRIVE) begin
            row_drv = (NUM_ROWS'(1) << row_idx) ^ ROW_INV;
            col_drv = (snap_row & {NUM_COLS{pwm_lit(pwm_phase, bright)}}) ^ COL_INV;
        end
    end

    // Registered pin drivers; reset forces them inactive immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_row <= ROW_INV;
            led_col <= COL_INV;
        end else begin
            led_row <= row_drv;
            led_col <= col_drv;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan with a small scan model feeding
// a scoreboard queue of expected pin states.
module tb_led_matrix_scan;

    localparam int NR = 5;
    localparam int NC = 8;
    localparam int SD = 64;
    localparam int BC = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [3:0]    bright;
    logic [NR*NC-1:0] frame_data;
    logic [NR-1:0] led_row;
    logic [NC-1:0] led_col;
    logic [2:0]    row_idx;
    logic          frame_start;

    typedef struct {
        logic [NR-1:0] row;
        logic [NC-1:0] col;
        logic [2:0]    idx;
        logic          fs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    int          m_run;
    int          m_slot;
    int          m_row;
    logic [NR*NC-1:0] m_snap;

    led_matrix_scan #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .SCAN_DIV       (SD),
        .BLANK_CYCLES   (BC),
        .ROW_ACTIVE_LOW (0),
        .COL_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bright      (bright),
        .frame_data  (frame_data),
        .led_row     (led_row),
        .led_col     (led_col),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scan model: on each edge, predict the registered pins from
    // the pre-edge scan position, then advance the position.
    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            m_run  = 0;
            m_slot = 0;
            m_row  = 0;
            m_snap = '0;
        end else begin
            e.row = '0;
            e.col = 8'hFF;
            if (m_run != 0 && m_slot >= BC) begin
                e.row = 5'b00001 << m_row;
                for (int c = 0; c < NC; c++) begin
                    if (m_snap[m_row*NC + c] && (((m_slot - BC) % 16) <= int'(bright)))
                        e.col[c] = 1'b0;
                end
            end
            if (m_run == 0) begin
                if (enable) begin
                    m_run  = 1;
                    m_slot = 0;
                    m_row  = 0;
                end
            end else begin
                if (m_slot == 0 && m_row == 0) m_snap = frame_data;
                if (m_slot == SD - 1) begin
                    m_slot = 0;
                    if (!enable) begin
                        m_run = 0;
                        m_row = 0;
                    end else begin
                        m_row = (m_row + 1) % NR;
                    end
                end else begin
                    m_slot = m_slot + 1;
                end
            end
            e.idx = 3'(m_row);
            e.fs  = (m_run != 0) && (m_slot == 0) && (m_row == 0);
            sb.push_back(e);
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        $display("[TB] test_reset");
        reset = 1'b1; enable = 1'b0; bright = 4'd15; frame_data = '1;
        @(negedge clk);
        n_cmp++;
        if ({led_row, led_col, row_idx, frame_start} !== {5'b0, 8'hFF, 3'd0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_pins got row=%b col=%h idx=%0d fs=%b exp row=00000 col=ff idx=0 fs=0",
                     led_row, led_col, row_idx, frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL reset_idle k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL reset_idle k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
        end
    endtask

    task automatic test_full_bright();
        exp_t e;
        int   fs_k[$];
        $display("[TB] test_full_bright");
        do_reset();
        bright = 4'd15; frame_data = '1;
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 660; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_k.push_back(k);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL full_bright k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL full_bright k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
        end
        n_cmp++;
        if (fs_k.size() != 3 || fs_k[0] != 1 || fs_k[1] != 321 || fs_k[2] != 641) begin
            n_err++;
            $display("[TB] FAIL frame_period got %0d pulses exp 3 pulses at k=1,321,641", fs_k.size());
        end
    endtask

    task automatic test_pwm_dim();
        exp_t e;
        int   lit1;
        int   lit2;
        int   row2_on;
        $display("[TB] test_pwm_dim");
        do_reset();
        bright = 4'd0;
        frame_data = {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
        lit1 = 0; lit2 = 0; row2_on = 0;
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 660; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL pwm_dim k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL pwm_dim k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
            if (k <= 330 && led_col === 8'h5A) lit1++;
            if (k > 330 && led_col === 8'h5A) lit2++;
            if (k <= 330 && led_row === 5'b00100) row2_on++;
            if (k == 330) bright = 4'd7;
        end
        n_cmp++;
        if (lit1 != 4) begin
            n_err++;
            $display("[TB] FAIL pwm_bright0 got %0d lit clocks exp 4", lit1);
        end
        n_cmp++;
        if (row2_on != 60) begin
            n_err++;
            $display("[TB] FAIL pwm_row2_active got %0d clocks exp 60", row2_on);
        end
        n_cmp++;
        if (lit2 != 32) begin
            n_err++;
            $display("[TB] FAIL pwm_bright7 got %0d lit clocks exp 32", lit2);
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        $display("[TB] test_snapshot");
        do_reset();
        bright = 4'd15;
        frame_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 340; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL snapshot k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL snapshot k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
            if (k == 204) begin
                n_cmp++;
                if ({led_row, led_col} !== {5'b01000, 8'hBB}) begin
                    n_err++;
                    $display("[TB] FAIL snap_row3_old got %b/%h exp 01000/bb", led_row, led_col);
                end
            end
            if (k == 270) begin
                n_cmp++;
                if ({led_row, led_col} !== {5'b10000, 8'hAA}) begin
                    n_err++;
                    $display("[TB] FAIL snap_row4_old got %b/%h exp 10000/aa", led_row, led_col);
                end
            end
            if (k == 332) begin
                n_cmp++;
                if ({led_row, led_col} !== {5'b00001, 8'h5E}) begin
                    n_err++;
                    $display("[TB] FAIL snap_row0_new got %b/%h exp 00001/5e", led_row, led_col);
                end
            end
            if (k == 150) frame_data = {8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        $display("[TB] test_enable_drop");
        do_reset();
        bright = 4'd15; frame_data = '1;
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL enable_drop k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL enable_drop k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
            if (k == 256) begin
                n_cmp++;
                if (row_idx !== 3'd3) begin
                    n_err++;
                    $display("[TB] FAIL drop_last_slot got idx=%0d exp 3", row_idx);
                end
            end
            if (k == 257) begin
                n_cmp++;
                if ({led_row, row_idx} !== {5'b01000, 3'd0}) begin
                    n_err++;
                    $display("[TB] FAIL drop_final_drive got %b/%0d exp 01000/0", led_row, row_idx);
                end
            end
            if (k == 258) begin
                n_cmp++;
                if ({led_row, led_col, row_idx} !== {5'b00000, 8'hFF, 3'd0}) begin
                    n_err++;
                    $display("[TB] FAIL drop_idle got %b/%h/%0d exp 00000/ff/0", led_row, led_col, row_idx);
                end
            end
            if (k == 281) begin
                n_cmp++;
                if ({frame_start, row_idx} !== {1'b1, 3'd0}) begin
                    n_err++;
                    $display("[TB] FAIL reenable_fs got fs=%b idx=%0d exp fs=1 idx=0", frame_start, row_idx);
                end
            end
            if (k == 203) enable = 1'b0;
            if (k == 280) enable = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        $display("[TB] test_back_to_back");
        do_reset();
        bright = 4'd15; frame_data = '1;
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL back_to_back k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL back_to_back k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
            if (k == 129) begin
                n_cmp++;
                if (row_idx !== 3'd2) begin
                    n_err++;
                    $display("[TB] FAIL cancel_row_adv got idx=%0d exp 2", row_idx);
                end
            end
            if (k == 136) begin
                n_cmp++;
                if ({led_row, led_col} !== {5'b00100, 8'h00}) begin
                    n_err++;
                    $display("[TB] FAIL cancel_drive got %b/%h exp 00100/00", led_row, led_col);
                end
            end
            if (k == 71) enable = 1'b0;
            if (k == 81) enable = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   active;
        $display("[TB] test_async_reset");
        do_reset();
        bright = 4'd15; frame_data = '1;
        sb.delete();
        enable = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL async_pre k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL async_pre k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
        end
        n_cmp++;
        if ({led_row, led_col} !== {5'b00001, 8'h00}) begin
            n_err++;
            $display("[TB] FAIL async_before got %b/%h exp 00001/00", led_row, led_col);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({led_row, led_col, row_idx, frame_start} !== {5'b0, 8'hFF, 3'd0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL async_clear got %b/%h/%0d/%b exp 00000/ff/0/0",
                     led_row, led_col, row_idx, frame_start);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        active = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL async_post k=%0d got empty scoreboard exp one entry", k);
            end else begin
                e = sb.pop_front();
                if ({led_row, led_col, row_idx, frame_start} !== {e.row, e.col, e.idx, e.fs}) begin
                    n_err++;
                    $display("[TB] FAIL async_post k=%0d got %b/%h/%0d/%b exp %b/%h/%0d/%b",
                             k, led_row, led_col, row_idx, frame_start, e.row, e.col, e.idx, e.fs);
                end
            end
            if (led_row !== 5'b0) active++;
        end
        n_cmp++;
        if (active != 0) begin
            n_err++;
            $display("[TB] FAIL async_stay_idle got %0d active clocks exp 0", active);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        enable = 1'b0;
        bright = 4'd0;
        frame_data = '0;
        test_reset();
        test_full_bright();
        test_pwm_dim();
        test_snapshot();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
